scan_doubler: RTL and testbench
===============================

# scan_doubler

Line-doubling scan converter directly downstream of the colour palette stage. Captures each 15 kHz input line of RGB332 pixels, delivered at one pixel per two clocks, into a ping-pong line buffer. Replays the previous line twice at one pixel per clock, producing a 31 kHz stream with its own DE/HSYNC for the VGA output stage. Overall latency is one input line.

## Interface
Parameters:
- H_ACTIVE, 256: active input pixels per line (buffer depth per bank)
- H_TOTAL, 384: output clocks per output line (= input pixel periods per input line)
- H_SYNC_START, 300: output h_cnt value where out_hsync asserts
- H_SYNC_LEN, 46: out_hsync width in clocks

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_pix_en  in  1  one-cycle input pixel strobe, at most every other cycle
- in_valid  in  1  palette stage video_valid; 0 means store black
- in_rgb  in  8  {r[2:0], g[2:0], b[1:0]} from the palette stage
- in_line_start  in  1  one-cycle pulse coincident with in_pix_en of input pixel 0
- in_vsync  in  1  input vertical sync, active-high
- out_rgb  out  8  doubled pixel data, 0 when out_de=0
- out_de  out  1  output data enable
- out_hsync  out  1  output horizontal sync, active-high
- out_vsync  out  1  in_vsync aligned to the output pipeline
- starved  out  1  high when no fresh line is available to replay

## Operation
- Storage: 2 banks × H_ACTIVE × 8 bits, held in one RAM with the bank bit as address MSB. Buffer is not cleared by reset.
- Write side: wr_bank, wr_addr.
  - On in_line_start: wr_bank toggles, the pixel is written to addr 0 of the new bank, wr_addr<=1.
  - On other in_pix_en with wr_addr<H_ACTIVE: write (in_valid ? in_rgb : 8'h00) at wr_addr, then wr_addr++.
  - wr_addr saturates at H_ACTIVE; extra pixels are dropped, never wrap.
- Read side: h_cnt 0..H_TOTAL-1, rep 0/1, rd_bank. States: IDLE (after reset), COPY0 (rep=0), COPY1 (rep=1), STARVED.
  - in_line_start from any state: rd_bank<=old wr_bank, h_cnt<=0, state COPY0, starved<=0.
  - h_cnt wrap in COPY0 → COPY1. Wrap in COPY1 → STARVED with starved<=1. In STARVED, h_cnt keeps counting and wrapping.
  - IDLE and STARVED: out_de=0, out_rgb=0. out_hsync and out_vsync still run.
- Pixel output: out_de=1 iff state ∈ {COPY0, COPY1} and h_cnt<H_ACTIVE. out_rgb = RAM[rd_bank, h_cnt] when out_de, else 0.
- out_hsync=1 iff H_SYNC_START ≤ h_cnt < H_SYNC_START+H_SYNC_LEN. This is independent of state, so sync is stable even when starved.
- Read and write never address the same bank during a replay unless two in_line_start pulses arrive within one output line. In that case the newest rule wins and the replay restarts.
- Widths: wr_addr/read addr are $clog2(H_ACTIVE)+1 bits (saturation needs the extra bit). h_cnt is $clog2(H_TOTAL) bits.

## Timing
- Reset values: out_rgb=0, out_de=0, out_hsync=0, out_vsync=0, starved=1, state IDLE, h_cnt=0, wr_bank=0, wr_addr=H_ACTIVE.
- Reset mid-line drops the current replay immediately.
- Read pipeline: h_cnt/state at cycle N → RAM address at N → registered out_* at N+2. out_hsync, out_de and out_vsync are delayed to match.
- in_line_start at cycle T: h_cnt=0 from T+1; out_de for pixel 0 at T+3.
- Nominal input line = 2·H_TOTAL clocks, so exactly COPY0 + COPY1 fill it. A late line gives STARVED black; an early line truncates COPY1.
- Write takes effect at the in_pix_en edge. A read of the same location in the same cycle is impossible, since it is always the opposite bank in nominal use.

## Structure
- scan_doubler_pkg: rgb332_t packed struct {r[2:0], g[2:0], b[1:0]}, sd_state_e enum (IDLE, COPY0, COPY1, STARVED), default timing localparams.
- Sub-module line_buffer_ram: simple dual-port, synchronous read (1 cycle), depth 2·H_ACTIVE, width 8. Has a SIMULATION variant and a vendor-IP variant, in the same style as the palette PROMs.

## Test plan
- Reset, then no input for 1000 clocks → out_de=0, out_rgb=0, starved=1, out_hsync pulses of 46 clocks every 384.
- Line A (pixel i = i[7:0]) then line B with nominal spacing → during B's input, output line A twice. Pixel 0 appears at T+3 after B's start, values 0..255 each copy, out_de high 256 clocks per copy.
- in_valid=0 for pixels 10..19 of a line → replay shows 8'h00 at those positions in both copies.
- 300 pixels in one line → pixels 256..299 dropped, next replay intact, no wrap corruption of addr 0.
- Omit one in_line_start → COPY0, COPY1, then STARVED (out_de=0, starved=1). The next line start resumes COPY0 with starved=0.
- rst asserted asynchronously mid-COPY1 → all outputs 0 the same cycle, starved=1. Recovery on the next line start.

Source files
------------

// File: rtl/scan_doubler_pkg.sv
`timescale 1ns/1ps
// Shared types and default timing for the line-doubling scan converter.
package scan_doubler_pkg;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic [1:0] {
    IDLE,
    COPY0,
    COPY1,
    STARVED
  } sd_state_e;

  localparam int H_ACTIVE_DEF     = 256;
  localparam int H_TOTAL_DEF      = 384;
  localparam int H_SYNC_START_DEF = 300;
  localparam int H_SYNC_LEN_DEF   = 46;

endpackage

// File: rtl/scan_doubler_line_buffer.sv
`timescale 1ns/1ps
// Ping-pong line store: simple dual-port RAM, one write and one
// registered read per clock; bank select is the address MSB.
module line_buffer_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

`ifdef LINE_BUFFER_VENDOR_IP
  sdp_ram_ip #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ip (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );
`else
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
`endif

endmodule

// File: rtl/scan_doubler.sv
`timescale 1ns/1ps
// Line doubler: captures 15 kHz input lines into a ping-pong buffer
// and replays the previous line twice at 31 kHz with its own timing.
module scan_doubler
  import scan_doubler_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_LEN   = H_SYNC_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_pix_en,
  input  logic       in_valid,
  input  logic [7:0] in_rgb,
  input  logic       in_line_start,
  input  logic       in_vsync,
  output logic [7:0] out_rgb,
  output logic       out_de,
  output logic       out_hsync,
  output logic       out_vsync,
  output logic       starved
);

  localparam int AW = $clog2(H_ACTIVE) + 1;
  localparam int HW = $clog2(H_TOTAL);

  localparam logic [AW-1:0] WR_FULL  = AW'(H_ACTIVE);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_SYNC_START);
  localparam logic [HW-1:0] HS_END   = HW'(H_SYNC_START + H_SYNC_LEN);

  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic [AW-1:0] wr_ram_addr;
  rgb332_t       wr_px;

  sd_state_e     state, state_n;
  logic [HW-1:0] h_cnt, h_cnt_n;
  logic          rd_bank, rd_bank_n;
  logic          starved_n;
  logic          wrap;
  logic [AW-1:0] rd_ram_addr;
  logic [7:0]    rd_data;

  logic          de0, hs0;
  logic          de1, hs1, vs1;

  // Line start always lands in the freshly toggled bank at address 0.
  always_comb begin
    wr_px       = in_valid ? rgb332_t'(in_rgb) : '0;
    wr_en       = 1'b0;
    wr_ram_addr = {wr_bank, wr_addr[AW-2:0]};
    if (in_line_start) begin
      wr_en       = in_pix_en;
      wr_ram_addr = {~wr_bank, {(AW-1){1'b0}}};
    end else if (in_pix_en && wr_addr < WR_FULL) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_addr <= WR_FULL;
    end else if (in_line_start) begin
      wr_bank <= ~wr_bank;
      wr_addr <= AW'(1);
    end else if (in_pix_en && wr_addr < WR_FULL) begin
      wr_addr <= wr_addr + 1'b1;
    end
  end

  assign wrap = (h_cnt == H_LAST);

  always_comb begin
    state_n   = state;
    rd_bank_n = rd_bank;
    starved_n = starved;
    h_cnt_n   = wrap ? '0 : h_cnt + 1'b1;
    if (in_line_start) begin
      state_n   = COPY0;
      rd_bank_n = wr_bank;
      starved_n = 1'b0;
      h_cnt_n   = '0;
    end else if (wrap) begin
      case (state)
        COPY0: state_n = COPY1;
        COPY1: begin
          state_n   = STARVED;
          starved_n = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      h_cnt   <= '0;
      rd_bank <= 1'b0;
      starved <= 1'b1;
    end else begin
      state   <= state_n;
      h_cnt   <= h_cnt_n;
      rd_bank <= rd_bank_n;
      starved <= starved_n;
    end
  end

  assign rd_ram_addr = {rd_bank, h_cnt[AW-2:0]};
  assign de0 = (state == COPY0 || state == COPY1) && (h_cnt < H_ACT);
  assign hs0 = (h_cnt >= HS_START) && (h_cnt < HS_END);

  line_buffer_ram #(
    .DEPTH (2 * H_ACTIVE),
    .AW    (AW),
    .DW    (8)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ram_addr),
    .wr_data (wr_px),
    .rd_addr (rd_ram_addr),
    .rd_data (rd_data)
  );

  // Stage 1 tracks the RAM read latency, stage 2 is the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de1       <= 1'b0;
      hs1       <= 1'b0;
      vs1       <= 1'b0;
      out_rgb   <= '0;
      out_de    <= 1'b0;
      out_hsync <= 1'b0;
      out_vsync <= 1'b0;
    end else begin
      de1       <= de0;
      hs1       <= hs0;
      vs1       <= in_vsync;
      out_rgb   <= de1 ? rd_data : '0;
      out_de    <= de1;
      out_hsync <= hs1;
      out_vsync <= vs1;
    end
  end

endmodule

// File: tb/tb_scan_doubler.sv
`timescale 1ns/1ps
// Directed bench for scan_doubler with a pixel scoreboard.
module tb_scan_doubler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_pix_en = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_rgb = '0;
  logic       in_line_start = 1'b0;
  logic       in_vsync = 1'b0;
  logic [7:0] out_rgb;
  logic       out_de;
  logic       out_hsync;
  logic       out_vsync;
  logic       starved;

  scan_doubler dut (
    .clk           (clk),
    .rst           (rst),
    .in_pix_en     (in_pix_en),
    .in_valid      (in_valid),
    .in_rgb        (in_rgb),
    .in_line_start (in_line_start),
    .in_vsync      (in_vsync),
    .out_rgb       (out_rgb),
    .out_de        (out_de),
    .out_hsync     (out_hsync),
    .out_vsync     (out_vsync),
    .starved       (starved)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         exp_q[$];
  logic [7:0] prev_line [256];
  bit         prev_ok = 1'b0;
  int         ls_edge = 0;
  bit         lat_armed = 1'b0;
  int         de_run = 0;
  logic       prev_de = 1'b0;
  int         e_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int i, input logic [7:0] seed);
    return (i < 256) ? (8'(i) ^ seed) : 8'hC3;
  endfunction

  // Scoreboard consumer: every out_de cycle pops one expected pixel.
  always @(negedge clk) begin
    if (rst) begin
      de_run  = 0;
      prev_de = 1'b0;
    end else begin
      if (out_de) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL sb_underflow observed=empty expected=entry cyc=%0d", cyc);
        end
        if (exp_q.size() > 0) begin
          e_m = exp_q.pop_front();
          if (e_m >= 0) begin
            checks++;
            assert (out_rgb === 8'(e_m)) else begin
              errors++;
              $error("FAIL pixel observed=%h expected=%h cyc=%0d", out_rgb, 8'(e_m), cyc);
            end
          end
        end
        if (!prev_de && lat_armed) begin
          checks++;
          assert (cyc == ls_edge + 2) else begin
            errors++;
            $error("FAIL latency observed=%0d expected=%0d", cyc - ls_edge, 2);
          end
          lat_armed = 1'b0;
        end
        de_run++;
      end else begin
        checks++;
        assert (out_rgb === 8'h00) else begin
          errors++;
          $error("FAIL blank_rgb observed=%h expected=00 cyc=%0d", out_rgb, cyc);
        end
        if (prev_de) begin
          checks++;
          assert (de_run == 256) else begin
            errors++;
            $error("FAIL de_run observed=%0d expected=256", de_run);
          end
          de_run = 0;
        end
      end
      prev_de = out_de;
    end
  end

  task automatic send_line(input bit start, input int periods, input int npix,
                           input int bad_lo, input int bad_hi,
                           input logic [7:0] seed,
                           output int n_de, output int n_stv);
    n_de  = 0;
    n_stv = 0;
    if (start) begin
      for (int c = 0; c < 2; c++)
        for (int k = 0; k < 256; k++)
          exp_q.push_back(prev_ok ? int'(prev_line[k]) : -1);
      for (int k = 0; k < 256; k++)
        prev_line[k] = (k >= bad_lo && k <= bad_hi) ? 8'h00 : pix_val(k, seed);
      prev_ok = 1'b1;
    end
    for (int i = 0; i < periods; i++) begin
      in_line_start = start && (i == 0);
      in_pix_en     = (i < npix);
      in_valid      = !(i >= bad_lo && i <= bad_hi);
      in_rgb        = pix_val(i, seed);
      @(posedge clk); #1;
      if (in_line_start) begin
        ls_edge   = cyc;
        lat_armed = 1'b1;
      end
      n_de  += int'(out_de);
      n_stv += int'(starved);
      in_line_start = 1'b0;
      in_pix_en     = 1'b0;
      @(posedge clk); #1;
      n_de  += int'(out_de);
      n_stv += int'(starved);
    end
  endtask

  int   rises[$];
  int   falls[$];
  logic ph;
  int   n_de, n_stv;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_rgb", 32'(out_rgb), 0);
    check("rst_de", 32'(out_de), 0);
    check("rst_hsync", 32'(out_hsync), 0);
    check("rst_vsync", 32'(out_vsync), 0);
    check("rst_starved", 32'(starved), 1);
    rst = 1'b0;

    // No input: blank, starved, free-running hsync.
    ph = 1'b0; n_de = 0; n_stv = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (out_hsync && !ph) rises.push_back(k);
      if (!out_hsync && ph) falls.push_back(k);
      ph = out_hsync;
      n_de  += int'(out_de);
      n_stv += int'(!starved);
    end
    check("idle_de_cycles", 32'(n_de), 0);
    check("idle_not_starved", 32'(n_stv), 0);
    check("hs_rises", 32'(rises.size()), 2);
    check("hs_falls", 32'(falls.size()), 2);
    if (rises.size() == 2 && falls.size() == 2) begin
      check("hs_period", 32'(rises[1] - rises[0]), 384);
      check("hs_len0", 32'(falls[0] - rises[0]), 46);
      check("hs_len1", 32'(falls[1] - rises[1]), 46);
    end

    in_vsync = 1'b1;
    @(posedge clk); #1;
    check("vsync_d1", 32'(out_vsync), 0);
    @(posedge clk); #1;
    check("vsync_d2", 32'(out_vsync), 1);
    in_vsync = 1'b0;

    send_line(1, 384, 384, -1, -1, 8'h00, n_de, n_stv);
    check("lineA_de", 32'(n_de), 512);
    check("lineA_stv", 32'(n_stv), 0);
    send_line(1, 384, 384, 10, 19, 8'h3C, n_de, n_stv);
    check("lineB_de", 32'(n_de), 512);
    send_line(1, 384, 300, -1, -1, 8'h96, n_de, n_stv);
    check("lineC_de", 32'(n_de), 512);
    send_line(1, 384, 384, -1, -1, 8'h21, n_de, n_stv);
    check("lineD_de", 32'(n_de), 512);
    check("lineD_stv", 32'(n_stv), 0);

    // Missing line start: replay runs out.
    send_line(0, 384, 384, -1, -1, 8'h77, n_de, n_stv);
    check("omit_de", 32'(n_de), 0);
    check("omit_stv", 32'(n_stv), 768);
    send_line(1, 384, 384, -1, -1, 8'h5A, n_de, n_stv);
    check("lineE_de", 32'(n_de), 512);
    check("lineE_stv", 32'(n_stv), 0);

    // Asynchronous reset in the middle of the second copy.
    in_vsync = 1'b1;
    send_line(1, 250, 250, -1, -1, 8'hE1, n_de, n_stv);
    check("pre_rst_de", 32'(out_de), 1);
    check("pre_rst_vsync", 32'(out_vsync), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_rgb", 32'(out_rgb), 0);
    check("arst_de", 32'(out_de), 0);
    check("arst_hsync", 32'(out_hsync), 0);
    check("arst_vsync", 32'(out_vsync), 0);
    check("arst_starved", 32'(starved), 1);
    exp_q.delete();
    prev_ok   = 1'b0;
    lat_armed = 1'b0;
    in_vsync  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("post_rst_starved", 32'(starved), 1);
    check("post_rst_de", 32'(out_de), 0);

    send_line(1, 384, 384, -1, -1, 8'h0F, n_de, n_stv);
    check("lineG_de", 32'(n_de), 512);
    check("lineG_stv", 32'(n_stv), 0);
    send_line(1, 384, 384, -1, -1, 8'hA5, n_de, n_stv);
    check("lineH_de", 32'(n_de), 512);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
